// File: rtl/right_shift_deserializer_pkg.sv
// Shared types and constants for the right-shift serial-to-parallel deserializer.
package right_shift_deserializer_pkg;

    localparam int DW_DEFAULT = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

endpackage

// File: rtl/right_shift_core.sv
// Right-shift register: each enabled edge moves sin into the MSB and drops the LSB.
module right_shift_core
    import right_shift_deserializer_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          async_rst,
    input  logic          shift_en,
    input  logic          sin,
    output logic [DW-1:0] sh
);

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            sh <= '0;
        end else if (shift_en) begin
            sh <= {sin, sh[DW-1:1]};
        end
    end

endmodule

// File: rtl/right_shift_deserializer.sv
// LSB-first serial deserializer with sync framing, valid/ready output and overrun flag.
module right_shift_deserializer
    import right_shift_deserializer_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          async_rst,
    input  logic          en,
    input  logic          sin,
    input  logic          sync,
    input  logic          dout_rdy,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    output logic          frame_err,
    output logic          overrun
);

    localparam int             CW       = $clog2(DW);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DW - 1);

    state_t          state, state_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic            shift_en;
    logic            word_done;
    logic            frame_err_d;
    logic [DW-1:0]   sh;
    logic [DW-1:0]   word;
    logic            unused_sh0;

    right_shift_core #(.DW(DW)) u_core (
        .clk       (clk),
        .async_rst (async_rst),
        .shift_en  (shift_en),
        .sin       (sin),
        .sh        (sh)
    );

    // The completing bit never lands in sh, so the word is formed combinationally;
    // sh[0] only ever holds a bit that is shifted out before completion.
    assign word       = {sin, sh[DW-1:1]};
    assign unused_sh0 = sh[0];

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        shift_en    = 1'b0;
        word_done   = 1'b0;
        frame_err_d = 1'b0;
        if (en) begin
            case (state)
                IDLE: begin
                    if (sync) begin
                        shift_en = 1'b1;
                        cnt_d    = CW'(1);
                        state_d  = RECV;
                    end
                end
                RECV: begin
                    shift_en = 1'b1;
                    if (sync) begin
                        cnt_d       = CW'(1);
                        frame_err_d = (cnt != '0);
                    end else if (cnt == CNT_LAST) begin
                        cnt_d     = '0;
                        word_done = 1'b1;
                    end else begin
                        cnt_d = cnt + CW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            state     <= IDLE;
            cnt       <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            frame_err <= frame_err_d;
        end
    end

    // A completed word is dropped only when the previous one is still pending.
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
        end else if (word_done) begin
            if (!dout_valid || dout_rdy) begin
                dout       <= word;
                dout_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (dout_valid && dout_rdy) begin
            dout_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_right_shift_deserializer.sv
// Directed bench for right_shift_deserializer (DW=4) with a queue of expected words.
module tb_right_shift_deserializer;

    logic       clk = 1'b0;
    logic       async_rst;
    logic       en;
    logic       sin;
    logic       sync;
    logic       dout_rdy;
    logic [3:0] dout;
    logic       dout_valid;
    logic       frame_err;
    logic       overrun;

    int         n_checks = 0;
    int         n_errors = 0;
    int         fe_count = 0;
    int         fe_base;
    logic [3:0] exp_q[$];

    right_shift_deserializer #(.DW(4)) dut (
        .clk        (clk),
        .async_rst  (async_rst),
        .en         (en),
        .sin        (sin),
        .sync       (sync),
        .dout_rdy   (dout_rdy),
        .dout       (dout),
        .dout_valid (dout_valid),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Counts cycles in which frame_err was high (sampled pre-update at each rising edge).
    always @(posedge clk) begin
        if (frame_err === 1'b1) fe_count++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One qualified strobe; returns at the following falling edge with outputs settled.
    task automatic strobe(input logic s, input logic b);
        en   = 1'b1;
        sync = s;
        sin  = b;
        @(negedge clk);
        en   = 1'b0;
        sync = 1'b0;
        sin  = 1'b0;
    endtask

    // bits[0] is sent first; sync accompanies the first bit when with_sync is set.
    task automatic send_word(input logic [3:0] bits, input logic with_sync);
        for (int i = 0; i < 4; i++) strobe(with_sync && (i == 0), bits[i]);
    endtask

    task automatic check_word(input string tag);
        logic [3:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_dout"}, dout, e);
            check({tag, "_valid"}, dout_valid, 1'b1);
        end
    endtask

    initial begin
        async_rst = 1'b1;
        en        = 1'b0;
        sin       = 1'b0;
        sync      = 1'b0;
        dout_rdy  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_dout", dout, 4'h0);
        check("rst_valid", dout_valid, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        async_rst = 1'b0;

        // Idle filtering: unsynced strobes are ignored, then one word 0,1,1,0.
        repeat (3) strobe(1'b0, 1'b1);
        check("idle_no_word", dout_valid, 1'b0);
        exp_q.push_back(4'h6);
        send_word(4'b0110, 1'b1);
        check_word("idle");
        dout_rdy = 1'b1;
        @(negedge clk);
        check("idle_accepted", dout_valid, 1'b0);
        check("idle_single_word", dout, 4'h6);

        // Basic word 1,0,1,1; sync at cnt==0 in RECV is a normal start.
        dout_rdy = 1'b0;
        fe_base  = fe_count;
        exp_q.push_back(4'hD);
        send_word(4'b1101, 1'b1);
        check_word("basic");
        dout_rdy = 1'b1;
        @(negedge clk);
        check("basic_accepted", dout_valid, 1'b0);
        check("basic_dout_hold", dout, 4'hD);
        check("basic_no_frame_err", fe_count - fe_base, 0);

        // Back-to-back: sync only on the first of 8 strobes.
        fe_base = fe_count;
        exp_q.push_back(4'h1);
        exp_q.push_back(4'hE);
        send_word(4'b0001, 1'b1);
        check_word("b2b1");
        send_word(4'b1110, 1'b0);
        check_word("b2b2");
        @(negedge clk);
        check("b2b_accepted", dout_valid, 1'b0);
        check("b2b_no_frame_err", fe_count - fe_base, 0);

        // Mid-word sync after 2 bits restarts the word and pulses frame_err once.
        fe_base = fe_count;
        exp_q.push_back(4'hF);
        strobe(1'b1, 1'b0);
        strobe(1'b0, 1'b1);
        strobe(1'b1, 1'b1);
        check("mid_frame_err_high", frame_err, 1'b1);
        strobe(1'b0, 1'b1);
        check("mid_frame_err_low", frame_err, 1'b0);
        check("mid_no_partial_word", dout_valid, 1'b0);
        strobe(1'b0, 1'b1);
        strobe(1'b0, 1'b1);
        check_word("mid");
        @(negedge clk);
        check("mid_frame_err_pulses", fe_count - fe_base, 1);

        // Overrun: second word arrives while the first is still pending.
        dout_rdy = 1'b0;
        exp_q.push_back(4'h3);
        send_word(4'b0011, 1'b1);
        check_word("ovr_first");
        check("ovr_not_yet", overrun, 1'b0);
        send_word(4'b0101, 1'b0);
        check("ovr_dout_kept", dout, 4'h3);
        check("ovr_valid_kept", dout_valid, 1'b1);
        check("ovr_set", overrun, 1'b1);
        dout_rdy = 1'b1;
        @(negedge clk);
        check("ovr_accepted", dout_valid, 1'b0);
        check("ovr_sticky", overrun, 1'b1);

        // Reset mid-word between edges, then a fresh word that needs sync.
        dout_rdy = 1'b0;
        strobe(1'b1, 1'b1);
        strobe(1'b0, 1'b0);
        #2 async_rst = 1'b1;
        #1;
        check("arst_dout", dout, 4'h0);
        check("arst_valid", dout_valid, 1'b0);
        check("arst_frame_err", frame_err, 1'b0);
        check("arst_overrun", overrun, 1'b0);
        @(negedge clk);
        async_rst = 1'b0;
        strobe(1'b0, 1'b1);
        strobe(1'b0, 1'b1);
        check("arst_needs_sync", dout_valid, 1'b0);
        exp_q.push_back(4'hA);
        send_word(4'b1010, 1'b1);
        check_word("arst_word");
        check("arst_overrun_clear", overrun, 1'b0);

        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/right_shift_deserializer.md
RIGHT_SHIFT_DESERIALIZER -- requirements
Module: right_shift_deserializer

Interface
REQ-001 Parameter DW, default 4: word width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 async_rst  input  1  asynchronous, active-high reset.
REQ-004 en  input  1  serial bit strobe; sin and sync are sampled only on edges where en=1.
REQ-005 sin  input  1  serial data bit, LSB of the word first.
REQ-006 sync  input  1  start-of-word marker, qualified by en; the bit carrying sync is bit 0.
REQ-007 dout_rdy  input  1  consumer accepts dout when dout_valid=1 and dout_rdy=1 on a rising edge.
REQ-008 dout  output  DW  last completed word, registered.
REQ-009 dout_valid  output  1  dout holds an unaccepted word.
REQ-010 frame_err  output  1  one-cycle pulse: sync arrived mid-word.
REQ-011 overrun  output  1  sticky: a completed word was dropped.

Function
REQ-012 Internal shift register sh[DW-1:0]: on each qualified bit, sh <= {sin, sh[DW-1:1]} (right shift, new bit enters MSB).
REQ-013 Bit counter cnt, range 0..DW-1, counts bits received in the current word.
REQ-014 FSM states: IDLE (no frame) and RECV (in frame).
REQ-015 IDLE: en=1 with sync=0 is ignored; en=1 with sync=1 shifts the bit in, sets cnt=1 and enters RECV.
REQ-016 RECV: en=1 with sync=0 shifts the bit in and increments cnt; when cnt==DW-1 the word completes and cnt wraps to 0; the state stays RECV so back-to-back words need no further sync.
REQ-017 RECV: en=1 with sync=1 and cnt!=0 discards the partial word, restarts with this bit as bit 0 (cnt=1), and pulses frame_err high for exactly one cycle.
REQ-018 RECV: en=1 with sync=1 and cnt==0 is a normal word start; frame_err is not raised.
REQ-019 Word completion value is {sin, sh[DW-1:1]}, so the first-received bit lands at dout[0].
REQ-020 Latency: dout and dout_valid update on the same rising edge that samples the last bit; both are visible in the following cycle.
REQ-021 On completion with dout_valid=0, or with dout_valid=1 and dout_rdy=1: dout loads the new word and dout_valid is 1.
REQ-022 On completion with dout_valid=1 and dout_rdy=0: the new word is dropped, dout is unchanged, and overrun is set.
REQ-023 With no completion, dout_valid=1 and dout_rdy=1: dout_valid clears and dout holds its value.
REQ-024 overrun is cleared only by reset.
REQ-025 With en=0, sh, cnt and the FSM state hold; the output handshake still operates.

Reset
REQ-026 When async_rst=1, immediately and independent of clk: state=IDLE, cnt=0, sh=0, dout=0, dout_valid=0, frame_err=0, overrun=0.
REQ-027 Reset mid-word discards the partial word; after release, the first word requires sync.
REQ-028 Release of async_rst is synchronous to the next clk rising edge; no strobe is lost beyond the edges during which reset is held.

Structure
REQ-029 A shared package holds the FSM state encoding (IDLE, RECV) and the default width constant DW_DEFAULT=4.
REQ-030 One sub-module, right_shift_core, provides sh with load-free shift enable; it is the counterpart of the team's right-shift register. All other logic sits at top level.

Verification (DW=4)
REQ-031 Basic word: sync on the first strobe, bits 1,0,1,1 -> dout=4'hD and dout_valid=1 in the cycle after the 4th strobe; dout_rdy=1 clears dout_valid one edge later.
REQ-032 Back-to-back: 8 strobes with sync only on the 1st, bits 1,0,0,0,0,1,1,1, dout_rdy=1 -> dout=4'h1 then 4'hE, no frame_err.
REQ-033 Idle filtering: 3 strobes without sync, then a sync word 0,1,1,0 -> exactly one word, dout=4'h6.
REQ-034 Mid-word sync: sync, 2 bits, then sync with bits 1,1,1,1 -> frame_err pulses 1 cycle; dout=4'hF.
REQ-035 Overrun: two words 4'h3 and 4'h5 with dout_rdy=0 -> dout stays 4'h3 and overrun=1; raising dout_rdy clears dout_valid while overrun stays 1.
REQ-036 Reset mid-word: assert async_rst between clk edges after 2 bits -> all outputs 0 immediately; the next sync word 4'hA is received correctly.
